// File: rtl/tron_pkg.sv
// tron_pkg: shared types and constants for the background loader.
// MAP_FILL and FILL_COLOR only take effect when the loader is built with
// BG_LOADER_FILL_EN defined.
package tron_pkg;

  // Loader sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    COPY  = 2'd2,
    DONE  = 2'd3
  } loader_state_e;

  // Map indices as stored in the ROM. MAP_MENU also serves as the
  // fallback for any out-of-range selection.
  localparam logic [2:0] MAP_MENU = 3'd0;
  localparam logic [2:0] MAP_FILL = 3'b111;

  // Colour written to every cell in fill mode.
  localparam logic [3:0] FILL_COLOR = 4'hC;

  // A decoded load command: which map to copy, or flood with FILL_COLOR.
  typedef struct packed {
    logic       fill;
    logic [2:0] sel;
  } load_cmd_t;

  // Number of cells in one map.
  function automatic int unsigned map_cells(input int unsigned w,
                                            input int unsigned h);
    return w * h;
  endfunction

endpackage

// File: rtl/fb_write_mux.sv
// fb_write_mux: combinational owner select for the single frame-buffer
// write port. While the loader owns the port the game writer is starved.
// Otherwise the game writer passes straight through. Its address and data
// are forced to zero when it is not requesting.
module fb_write_mux #(
  parameter int FB_AW = 13,
  parameter int PIX_W = 4
) (
  input  logic             loader_own_i,
  input  logic             ld_we_i,
  input  logic [FB_AW-1:0] ld_addr_i,
  input  logic [PIX_W-1:0] ld_data_i,
  input  logic             gw_req_i,
  input  logic [FB_AW-1:0] gw_addr_i,
  input  logic [PIX_W-1:0] gw_data_i,
  input  logic             fb_ready_i,
  output logic             gw_gnt_o,
  output logic             fb_we_o,
  output logic [FB_AW-1:0] fb_addr_o,
  output logic [PIX_W-1:0] fb_data_o
);

  // Port select: the loader wins outright, otherwise the game writer passes through.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    fb_we_o   = gw_req_i;
    fb_addr_o = gw_req_i ? gw_addr_i : '0;
    fb_data_o = gw_req_i ? gw_data_i : '0;
    gw_gnt_o  = gw_req_i & fb_ready_i;
    if (loader_own_i) begin
      fb_we_o   = ld_we_i;
      fb_addr_o = ld_addr_i;
      fb_data_o = ld_data_i;
      gw_gnt_o  = 1'b0;
    end
  end

endmodule

// File: rtl/background_loader.sv
// background_loader: copies one full map from the map ROM into the frame
// buffer on request. It owns the frame-buffer write port and shares that
// port with the in-game writer.
// Optional build macro BG_LOADER_FILL_EN: map_sel = 3'b111 floods every
// cell with FILL_COLOR. In that mode the ROM is not read and the prime
// cycle is skipped.
module background_loader
  import tron_pkg::*;
#(
  parameter int MAP_W    = 80,
  parameter int MAP_H    = 60,
  parameter int NUM_MAPS = 5,
  parameter int PIX_W    = 4,
  parameter int FB_AW    = 13,
  parameter int ROM_AW   = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              load_req,
  input  logic [2:0]        map_sel,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  input  logic              gw_req,
  input  logic [FB_AW-1:0]  gw_addr,
  input  logic [PIX_W-1:0]  gw_data,
  output logic              gw_gnt,
  output logic              fb_we,
  output logic [FB_AW-1:0]  fb_addr,
  output logic [PIX_W-1:0]  fb_data,
  input  logic              fb_ready
);

  localparam int unsigned       CELLS    = map_cells(MAP_W, MAP_H);
  localparam logic [FB_AW-1:0]  LAST_IDX = FB_AW'(CELLS - 1);
  localparam logic [ROM_AW-1:0] CELLS_R  = ROM_AW'(CELLS);

`ifdef BG_LOADER_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  // Folds an unknown map index onto the menu map. When fill mode is
  // enabled, the fill code is decoded first.
  function automatic load_cmd_t decode_sel(input logic [2:0] s);
    load_cmd_t c;
    c.fill = 1'b0;
    c.sel  = s;
    if (FILL_EN && (s == MAP_FILL)) begin
      c.fill = 1'b1;
      c.sel  = MAP_MENU;
    end else if (int'(s) >= NUM_MAPS) begin
      c.sel = MAP_MENU;
    end
    return c;
  endfunction

  // A ROM copy needs one prime cycle for the first read. A fill does not.
  function automatic loader_state_e start_state(input load_cmd_t c);
    return c.fill ? COPY : PRIME;
  endfunction

  loader_state_e     state_q, state_d;
  load_cmd_t         cmd_q, cmd_d;          // copy in progress
  load_cmd_t         pend_cmd_q, pend_cmd_d;
  logic              pend_q, pend_d;        // one-deep request queue
  logic [FB_AW-1:0]  idx_q, idx_d;          // cell currently on rom_data

  load_cmd_t         req_cmd;
  logic              last_cell;
  logic [ROM_AW-1:0] base_addr;

  logic              loader_own;
  logic              ld_we;
  logic [FB_AW-1:0]  ld_addr;
  logic [PIX_W-1:0]  ld_data;

  assign req_cmd   = decode_sel(map_sel);
  assign last_cell = (idx_q == LAST_IDX);
  assign base_addr = ROM_AW'(cmd_q.sel) * CELLS_R;

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: a request in DONE, or a pending one, chains straight into the next copy.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (load_req) state_d = start_state(req_cmd);
      PRIME: state_d = COPY;
      COPY:  if (fb_ready && last_cell) state_d = DONE;
      DONE: begin
        if (load_req)    state_d = start_state(req_cmd);
        else if (pend_q) state_d = start_state(pend_cmd_q);
        else             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command, pending-request and cell-index bookkeeping.
  always_comb begin
    cmd_d      = cmd_q;
    pend_d     = pend_q;
    pend_cmd_d = pend_cmd_q;
    idx_d      = idx_q;
    unique case (state_q)
      IDLE: begin
        if (load_req) begin
          cmd_d = req_cmd;
          idx_d = '0;
        end
      end
      PRIME, COPY: begin
        // The latest request overwrites any earlier pending one.
        if (load_req) begin
          pend_d     = 1'b1;
          pend_cmd_d = req_cmd;
        end
        if ((state_q == COPY) && fb_ready && !last_cell) idx_d = idx_q + FB_AW'(1);
      end
      DONE: begin
        idx_d = '0;
        if (load_req) begin
          cmd_d  = req_cmd;
          pend_d = 1'b0;
        end else if (pend_q) begin
          cmd_d  = pend_cmd_q;
          pend_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers. Reset abandons any copy in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cmd_q      <= '0;
      pend_cmd_q <= '0;
      pend_q     <= 1'b0;
      idx_q      <= '0;
    end else begin
      cmd_q      <= cmd_d;
      pend_cmd_q <= pend_cmd_d;
      pend_q     <= pend_d;
      idx_q      <= idx_d;
    end
  end

  // Outputs: the ROM prefetches cell i+1 only when cell i is accepted, and holds during a stall.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    rom_en   = 1'b0;
    rom_addr = '0;
    ld_we    = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    unique case (state_q)
      PRIME: begin
        busy     = 1'b1;
        rom_en   = 1'b1;
        rom_addr = base_addr;
      end
      COPY: begin
        busy    = 1'b1;
        ld_we   = 1'b1;
        ld_addr = idx_q;
        ld_data = cmd_q.fill ? PIX_W'(FILL_COLOR) : rom_data;
        if (!cmd_q.fill) begin
          rom_addr = base_addr + ROM_AW'(idx_q);
          if (fb_ready && !last_cell) begin
            rom_en   = 1'b1;
            rom_addr = base_addr + ROM_AW'(idx_q) + ROM_AW'(1);
          end
        end
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign loader_own = busy;

  fb_write_mux #(
    .FB_AW (FB_AW),
    .PIX_W (PIX_W)
  ) u_fb_write_mux (
    .loader_own_i (loader_own),
    .ld_we_i      (ld_we),
    .ld_addr_i    (ld_addr),
    .ld_data_i    (ld_data),
    .gw_req_i     (gw_req),
    .gw_addr_i    (gw_addr),
    .gw_data_i    (gw_data),
    .fb_ready_i   (fb_ready),
    .gw_gnt_o     (gw_gnt),
    .fb_we_o      (fb_we),
    .fb_addr_o    (fb_addr),
    .fb_data_o    (fb_data)
  );

endmodule

// File: tb/tb_background_loader.sv
// tb_background_loader: scoreboard bench for background_loader.
// It uses small maps (4x2 cells, 2 maps) and a one-cycle-latency ROM model.
// Define BG_LOADER_FILL_EN to exercise fill mode.
`timescale 1ns/1ps
module tb_background_loader;
  import tron_pkg::*;

  localparam int MAP_W    = 4;
  localparam int MAP_H    = 2;
  localparam int NUM_MAPS = 2;
  localparam int PIX_W    = 4;
  localparam int FB_AW    = 3;
  localparam int ROM_AW   = 4;
  localparam int CELLS    = MAP_W * MAP_H;

  logic              Clk      = 1'b0;
  logic              Reset_n  = 1'b0;
  logic              load_req = 1'b0;
  logic [2:0]        map_sel  = '0;
  logic              busy, done, rom_en, gw_gnt, fb_we;
  logic [ROM_AW-1:0] rom_addr;
  logic [PIX_W-1:0]  rom_data = '0;
  logic              gw_req   = 1'b0;
  logic [FB_AW-1:0]  gw_addr  = '0;
  logic [PIX_W-1:0]  gw_data  = '0;
  logic [FB_AW-1:0]  fb_addr;
  logic [PIX_W-1:0]  fb_data;
  logic              fb_ready = 1'b1;

  always #5 Clk = ~Clk;

  background_loader #(
    .MAP_W (MAP_W), .MAP_H (MAP_H), .NUM_MAPS (NUM_MAPS),
    .PIX_W (PIX_W), .FB_AW (FB_AW), .ROM_AW (ROM_AW)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .load_req (load_req),
    .map_sel  (map_sel),
    .busy     (busy),
    .done     (done),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .gw_req   (gw_req),
    .gw_addr  (gw_addr),
    .gw_data  (gw_data),
    .gw_gnt   (gw_gnt),
    .fb_we    (fb_we),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .fb_ready (fb_ready)
  );

  // ROM contents: a bijective pattern, so every address reads back distinct data.
  function automatic logic [PIX_W-1:0] rom_fn(input int a);
    return PIX_W'((a * 5 + 3) % 16);
  endfunction

  // ROM model: one cycle of read latency. The data is held while rom_en is low.
  always @(posedge Clk) if (rom_en) rom_data <= rom_fn(int'(rom_addr));

  typedef struct packed {
    logic [FB_AW-1:0] addr;
    logic [PIX_W-1:0] data;
  } wr_t;

  wr_t               exp_fb_q[$];
  wr_t               gw_exp_q[$];
  logic [ROM_AW-1:0] exp_rom_q[$];
  int                tests_run    = 0;
  int                tests_failed = 0;

  // Expected ROM reads and loader writes for one copy of the given selection.
  task automatic push_expect(input int sel);
    bit fill;
    int m;
    fill = 1'b0;
    m    = sel;
`ifdef BG_LOADER_FILL_EN
    if (sel == 7) fill = 1'b1;
`endif
    if (fill || m >= NUM_MAPS) m = 0;
    for (int i = 0; i < CELLS; i++) begin
      exp_fb_q.push_back('{addr: FB_AW'(i),
                           data: fill ? PIX_W'(FILL_COLOR) : rom_fn(m * CELLS + i)});
      if (!fill) exp_rom_q.push_back(ROM_AW'(m * CELLS + i));
    end
  endtask

  // Monitor: pops the scoreboards on every ROM read, loader write and game-writer grant.
  wr_t               mon_w;
  logic [ROM_AW-1:0] mon_r;
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (rom_en) begin
        tests_run++;
        if (exp_rom_q.size() == 0) begin
          tests_failed++;
          $display("FAIL rom_read: unexpected rom_en, rom_addr=%0d", rom_addr);
        end else begin
          mon_r = exp_rom_q.pop_front();
          if (rom_addr !== mon_r) begin
            tests_failed++;
            $display("FAIL rom_addr: got %0d want %0d", rom_addr, mon_r);
          end
        end
      end
      if (busy && fb_we && fb_ready) begin
        tests_run++;
        if (exp_fb_q.size() == 0) begin
          tests_failed++;
          $display("FAIL loader_write: unexpected write addr=%0d data=%0h", fb_addr, fb_data);
        end else begin
          mon_w = exp_fb_q.pop_front();
          if ({fb_addr, fb_data} !== mon_w) begin
            tests_failed++;
            $display("FAIL loader_write: got addr=%0d data=%0h want addr=%0d data=%0h",
                     fb_addr, fb_data, mon_w.addr, mon_w.data);
          end
        end
      end
      if (gw_gnt) begin
        tests_run++;
        if (gw_exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL gw_write: unexpected grant addr=%0d", fb_addr);
        end else begin
          mon_w = gw_exp_q.pop_front();
          if ({fb_we, fb_addr, fb_data} !== {1'b1, mon_w}) begin
            tests_failed++;
            $display("FAIL gw_write: got we=%0b addr=%0d data=%0h want addr=%0d data=%0h",
                     fb_we, fb_addr, fb_data, mon_w.addr, mon_w.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Drives a one-cycle load request and pushes the expected copy to the scoreboard.
  task automatic run_load(input int sel);
    load_req = 1'b1;
    map_sel  = 3'(sel);
    push_expect(sel);
    tick();
    load_req = 1'b0;
  endtask

  // Counts cycles after the load cycle until done. Returns -1 if done never comes.
  // Also counts busy-low cycles seen before done.
  task automatic wait_done(input int start, input int budget,
                           output int lat, output int gap);
    int  n;
    bit  seen;
    lat  = -1;
    gap  = 0;
    n    = start;
    seen = 1'b0;
    while (!seen && n <= budget) begin
      @(negedge Clk);
      if (done) begin
        lat  = n;
        seen = 1'b1;
      end else begin
        if (!busy) gap++;
        tick();
        n++;
      end
    end
  endtask

  task automatic check_queues(input string name);
    tests_run++;
    if (exp_fb_q.size() + exp_rom_q.size() + gw_exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_queues: leftover fb=%0d rom=%0d gw=%0d want 0",
               name, exp_fb_q.size(), exp_rom_q.size(), gw_exp_q.size());
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, rom_en, fb_we, gw_gnt} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b want 00000", {busy, done, rom_en, fb_we, gw_gnt});
    end
    tests_run++;
    if ({rom_addr, fb_addr, fb_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_bus: got rom_addr=%0d fb_addr=%0d fb_data=%0h want 0",
               rom_addr, fb_addr, fb_data);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();
    tests_run++;
    if ({busy, done, fb_we} !== 3'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: got busy/done/we=%b want 000", {busy, done, fb_we});
    end
  endtask

  task automatic test_basic();
    int lat, gap;
    run_load(1);
    wait_done(1, 60, lat, gap);
    tests_run++;
    if (lat !== CELLS + 2) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d want %0d", lat, CELLS + 2);
    end
    tests_run++;
    if (gap !== 0) begin
      tests_failed++;
      $display("FAIL basic_busy: busy low %0d cycles want 0", gap);
    end
    tick();
    tests_run++;
    if ({done, busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL basic_done_pulse: got done/busy=%b want 00", {done, busy});
    end
    check_queues("basic");
  endtask

  task automatic test_stall();
    int lat, gap;
    run_load(1);
    repeat (4) tick();               // cell 3 is on the bus in this cycle
    fb_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge Clk);
      tests_run++;
      if ({fb_we, fb_addr, fb_data, rom_en, busy} !== {1'b1, 3'd3, rom_fn(11), 1'b0, 1'b1}) begin
        tests_failed++;
        $display("FAIL stall_hold: got we=%0b addr=%0d data=%0h rom_en=%0b busy=%0b want 1/3/%0h/0/1",
                 fb_we, fb_addr, fb_data, rom_en, busy, rom_fn(11));
      end
      tick();
    end
    fb_ready = 1'b1;
    wait_done(8, 60, lat, gap);
    tests_run++;
    if (lat !== CELLS + 2 + 3) begin
      tests_failed++;
      $display("FAIL stall_latency: got %0d want %0d", lat, CELLS + 5);
    end
    tick();
    check_queues("stall");
  endtask

  task automatic test_gw_priority();
    int k, grants, lat;
    bit gnt_busy, gnt0, gnt_done;
    k = 0; grants = 0; lat = -1;
    gnt_busy = 1'b0; gnt0 = 1'b0; gnt_done = 1'b0;
    gw_req  = 1'b1;
    gw_addr = FB_AW'(k + 1);
    gw_data = PIX_W'(3 * k + 1);
    gw_exp_q.push_back('{addr: gw_addr, data: gw_data});
    load_req = 1'b1;
    map_sel  = 3'd1;
    push_expect(1);
    for (int n = 0; n < 14; n++) begin
      @(negedge Clk);
      if (busy && gw_gnt) gnt_busy = 1'b1;
      if (n == 0) gnt0 = gw_gnt;
      if (done) begin
        lat      = n;
        gnt_done = gw_gnt;
      end
      if (gw_gnt) grants++;
      tick();
      load_req = 1'b0;
      if (grants > k) begin
        k++;
        gw_addr = FB_AW'(k + 1);
        gw_data = PIX_W'(3 * k + 1);
        gw_exp_q.push_back('{addr: gw_addr, data: gw_data});
      end
    end
    gw_req = 1'b0;
    void'(gw_exp_q.pop_back());      // last item was never presented at a sample point
    tests_run++;
    if (gnt0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL gw_simultaneous: gnt=%0b want 1", gnt0);
    end
    tests_run++;
    if (gnt_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL gw_busy_gnt: grant seen while busy, want none");
    end
    tests_run++;
    if ({lat, gnt_done} !== {32'(CELLS + 2), 1'b1}) begin
      tests_failed++;
      $display("FAIL gw_done: got lat=%0d gnt=%0b want %0d/1", lat, gnt_done, CELLS + 2);
    end
    tests_run++;
    if (grants !== 5) begin
      tests_failed++;
      $display("FAIL gw_grants: got %0d want 5", grants);
    end
    check_queues("gw");
  endtask

  task automatic test_pending();
    int cnt, d1, d2;
    cnt = 0; d1 = -1; d2 = -1;
    run_load(0);                     // now in cycle 1
    repeat (2) tick();
    load_req = 1'b1;                 // cycle 3: request for map 0 (to be overwritten)
    map_sel  = 3'd0;
    tick();
    load_req = 1'b0;
    tick();
    load_req = 1'b1;                 // cycle 5: latest request, map 1
    map_sel  = 3'd1;
    push_expect(1);
    tick();
    load_req = 1'b0;
    for (int n = 6; n < 35; n++) begin
      @(negedge Clk);
      if (done) begin
        cnt++;
        if (cnt == 1) d1 = n;
        if (cnt == 2) d2 = n;
      end
      tick();
    end
    tests_run++;
    if ({cnt, d1, d2} !== {32'd2, 32'(CELLS + 2), 32'(2 * CELLS + 4)}) begin
      tests_failed++;
      $display("FAIL pending: got %0d dones at %0d,%0d want 2 at %0d,%0d",
               cnt, d1, d2, CELLS + 2, 2 * CELLS + 4);
    end
    check_queues("pending");
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, gap1, gap2;
    run_load(1);
    wait_done(1, 60, lat1, gap1);
    load_req = 1'b1;                 // request during the DONE cycle
    map_sel  = 3'd0;
    push_expect(0);
    tick();
    load_req = 1'b0;
    wait_done(1, 60, lat2, gap2);
    tests_run++;
    if ({lat1, lat2, gap2} !== {32'(CELLS + 2), 32'(CELLS + 2), 32'd0}) begin
      tests_failed++;
      $display("FAIL back_to_back: got lat=%0d,%0d gap=%0d want %0d,%0d,0",
               lat1, lat2, gap2, CELLS + 2, CELLS + 2);
    end
    tick();
    check_queues("b2b");
  endtask

  task automatic test_reset_mid_copy();
    bit dseen, bseen;
    dseen = 1'b0; bseen = 1'b0;
    run_load(1);
    repeat (6) tick();               // cell 5 is on the bus
    #2;
    Reset_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, rom_en, fb_we, gw_gnt, rom_addr, fb_addr, fb_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_copy: outputs not cleared, busy=%0b we=%0b fb_addr=%0d",
               busy, fb_we, fb_addr);
    end
    exp_fb_q.delete();
    exp_rom_q.delete();
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();
    for (int n = 0; n < 12; n++) begin
      @(negedge Clk);
      if (done) dseen = 1'b1;
      if (busy) bseen = 1'b1;
      tick();
    end
    tests_run++;
    if ({dseen, bseen} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_no_resume: done_seen=%0b busy_seen=%0b want 0/0", dseen, bseen);
    end
    check_queues("reset_mid");
  endtask

  task automatic test_bad_sel();
    int lat, gap, want7;
`ifdef BG_LOADER_FILL_EN
    want7 = CELLS + 1;
`else
    want7 = CELLS + 2;
`endif
    run_load(6);
    wait_done(1, 60, lat, gap);
    tests_run++;
    if (lat !== CELLS + 2) begin
      tests_failed++;
      $display("FAIL sel6_latency: got %0d want %0d", lat, CELLS + 2);
    end
    tick();
    run_load(7);
    wait_done(1, 60, lat, gap);
    tests_run++;
    if (lat !== want7) begin
      tests_failed++;
      $display("FAIL sel7_latency: got %0d want %0d", lat, want7);
    end
    tick();
    check_queues("bad_sel");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_gw_priority();
    test_pending();
    test_back_to_back();
    test_reset_mid_copy();
    test_bad_sel();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/background_loader.md
Name: background_loader

Overview:
- Sequences a full-screen background copy from the map ROM into the shared frame buffer whenever the game state machine requests a background load.
- Owns the single frame-buffer write port and arbitrates it between itself and the in-game trail/sprite writer.
- Sits between the game state controller (load_background, background_select) and the frame-buffer memory.

Parameters:
MAP_W, 80, map width in cells
MAP_H, 60, map height in cells
NUM_MAPS, 5, number of maps stored back-to-back in the ROM
PIX_W, 4, colour-index width per cell
FB_AW, 13, frame-buffer address width (must satisfy 2**FB_AW >= MAP_W*MAP_H)
ROM_AW, 16, ROM address width (must satisfy 2**ROM_AW >= NUM_MAPS*MAP_W*MAP_H)

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous, active-low reset
load_req  in  1  single-cycle load request (driven by load_background)
map_sel  in  3  map index, sampled on the accepted load_req
busy  out  1  high while a copy is in progress
done  out  1  one-cycle pulse after the last cell is written
rom_en  out  1  ROM read enable
rom_addr  out  ROM_AW  ROM read address
rom_data  in  PIX_W  ROM data, valid 1 cycle after rom_en; held while rom_en=0
gw_req  in  1  game writer request
gw_addr  in  FB_AW  game writer address
gw_data  in  PIX_W  game writer data
gw_gnt  out  1  game write accepted this cycle
fb_we  out  1  frame-buffer write strobe
fb_addr  out  FB_AW  frame-buffer address
fb_data  out  PIX_W  frame-buffer data
fb_ready  in  1  frame buffer accepts a write this cycle

Behaviour:
- Reset (asynchronous, any time, including mid-copy): state IDLE, counters 0, pending flag 0. Outputs busy, done, rom_en, fb_we, gw_gnt = 0; rom_addr, fb_addr, fb_data = 0. An aborted copy is not resumed.
- States:
  - IDLE: load_req latches map_sel into sel_q. If map_sel >= NUM_MAPS, sel_q = 0. Go to PRIME.
  - PRIME: rom_en=1, rom_addr = base + 0, where base = sel_q*MAP_W*MAP_H (compute with ROM_AW-bit arithmetic, no truncation). Go to COPY.
  - COPY: rom_data for index i is valid.
    - If fb_ready: fb_we=1, fb_addr=i, fb_data=rom_data. If i is not the last index, rom_en=1 and rom_addr = base+i+1, then i++.
    - If !fb_ready: fb_we=1 is still presented, rom_en=0, rom_addr and i are held.
    - When i = MAP_W*MAP_H-1 is accepted, go to DONE.
  - DONE: done=1 for one cycle, busy drops. Go to IDLE, or to PRIME if the pending flag is set.
- Throughput: 1 cell/cycle with fb_ready held high; total load = MAP_W*MAP_H + 2 cycles from load_req to done.
- busy=1 in PRIME and COPY, and registered-high from the cycle after the accepted load_req.
- Arbitration:
  - While busy: loader has absolute priority; gw_gnt=0.
  - In IDLE/DONE: fb_we = gw_req, fb_addr/fb_data = gw_*, gw_gnt = gw_req & fb_ready (combinational pass-through).
- load_req while busy: sets a one-deep pending flag and overwrites pending_sel (latest request wins). The pending copy starts from DONE. load_req in DONE is treated the same as pending.
- Simultaneous load_req and gw_req in IDLE: the game write for that cycle is granted; the loader starts next cycle.

Optional Feature:
- Macro BG_LOADER_FILL_EN.
- Defined: map_sel = 3'b111 selects fill mode.
  - ROM is not read (rom_en stays 0).
  - Every cell is written with constant FILL_COLOR from the package.
  - PRIME is skipped; latency = MAP_W*MAP_H + 1 cycles.
- Undefined: 3'b111 is out-of-range and maps to 0.

Decomposition:
- Package tron_pkg holds:
  - loader state enum (IDLE, PRIME, COPY, DONE)
  - FILL_COLOR constant
  - MAP_CELLS localparam function
  - map index constants (MAP_MENU=0 etc.)
- One natural sub-module: fb_write_mux, the combinational port mux/grant between loader and game writer.

Test Plan:
- Small params (MAP_W=4, MAP_H=2, NUM_MAPS=2), fb_ready=1, load_req with map_sel=1 -> rom_addr sequence 8..15; fb_addr 0..7 with matching data; done exactly 10 cycles after load_req; busy high between.
- Same, with fb_ready low for 3 cycles at cell 3 -> fb_addr holds at 3 with stable data, rom_en=0 during the stall; done delayed by exactly 3 cycles.
- gw_req held high throughout a load -> gw_gnt=0 while busy; gw_gnt=1 in the cycle after done; no game write lost or duplicated.
- Two load_req pulses during a copy (map 0 then map 1) -> a single follow-on copy of map 1 (rom_addr starts at 8); exactly two done pulses total.
- Reset_n asserted mid-copy at cell 5 -> all outputs 0 immediately (asynchronously); after release, IDLE; no done pulse.
- map_sel=6 -> copy of map 0; with BG_LOADER_FILL_EN, map_sel=7 -> 8 writes of FILL_COLOR, rom_en never asserted, done 9 cycles after load_req.
